// File: rtl/etarget_pkg.sv
// Shared definitions for the electronic-target shot sequencer: FSM state
// encoding and the run-flag bit positions of the four counters.
package etarget_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ARMED   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4,
      ST_HOLD    = 3'd5
   } seq_state_t;

   localparam int N = 0;
   localparam int E = 1;
   localparam int S = 2;
   localparam int W = 3;

   function automatic logic all_hit(input logic [3:0] mask);
      return mask[N] & mask[E] & mask[S] & mask[W];
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable saturating up-counter with a compare output; shared by the
// capture window and the post-shot hold-off.
module seq_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk8M,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   output logic             hit
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk8M) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (en && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   // Magnitude compare so that lowering the limit below the running count
   // mid-phase still ends the phase at once instead of waiting forever.
   assign hit = (count_reg >= limit);

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: clears the four counters, waits for the first hit, captures
// until all four fire or the window expires, then holds off before re-arming.
module shot_sequencer
   import etarget_pkg::*;
#(
   parameter int WIN_W  = 16,
   parameter int HOLD_W = 12
) (
   input  logic              clk8M,
   input  logic              reset,
   input  logic              arm,
   input  logic              disarm,
   input  logic              ack,
   input  logic              auto_rearm,
   input  logic [3:0]        run,
   input  logic [WIN_W-1:0]  window_max,
   input  logic [HOLD_W-1:0] holdoff_max,
   output logic              clear,
   output logic              stop,
   output logic              busy,
   output logic              ready,
   output logic              timeout,
   output logic [3:0]        hit_mask,
   output logic [7:0]        shot_count,
   output logic [2:0]        state
);

   localparam int TMR_W = (WIN_W > HOLD_W) ? WIN_W : HOLD_W;
   localparam logic [TMR_W-1:0] TMR_ZERO = '0;

   seq_state_t       state_reg;
   logic             clear_reg;
   logic             stop_reg;
   logic             busy_reg;
   logic             ready_reg;
   logic             timeout_reg;
   logic [3:0]       hit_mask_reg;
   logic [3:0]       acc_reg;
   logic [3:0]       acc_next;
   logic [7:0]       shot_count_reg;
   logic             tmr_en;
   logic             tmr_load;
   logic             tmr_hit;
   logic [TMR_W-1:0] tmr_limit;

   // The timer sits at zero outside the timed phases, so entering CAPTURE or
   // HOLD always starts the count from zero.
   always_comb begin
      tmr_en    = (state_reg == ST_CAPTURE) || (state_reg == ST_HOLD);
      tmr_load  = !tmr_en;
      tmr_limit = (state_reg == ST_CAPTURE) ? TMR_W'(window_max) : TMR_W'(holdoff_max);
      acc_next  = acc_reg | run;
   end

   seq_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk8M      (clk8M),
      .reset      (reset),
      .load       (tmr_load),
      .en         (tmr_en),
      .load_value (TMR_ZERO),
      .limit      (tmr_limit),
      .hit        (tmr_hit)
   );

   always_ff @(posedge clk8M) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         clear_reg      <= 1'b0;
         stop_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         ready_reg      <= 1'b0;
         timeout_reg    <= 1'b0;
         hit_mask_reg   <= '0;
         acc_reg        <= '0;
         shot_count_reg <= '0;
      end else begin
         clear_reg <= 1'b0;
         stop_reg  <= 1'b0;
         if (disarm && (state_reg != ST_IDLE)) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            stop_reg  <= (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (arm && !disarm) begin
                     state_reg <= ST_CLEAR;
                     clear_reg <= 1'b1;
                     busy_reg  <= 1'b1;
                  end
               end
               ST_CLEAR: begin
                  state_reg <= ST_ARMED;
                  acc_reg   <= '0;
               end
               ST_ARMED: begin
                  if (|run) begin
                     state_reg <= ST_CAPTURE;
                     acc_reg   <= run;
                  end
               end
               ST_CAPTURE: begin
                  acc_reg <= acc_next;
                  // All four counters firing outranks a same-cycle expiry.
                  if (all_hit(acc_next) || tmr_hit) begin
                     state_reg      <= ST_DONE;
                     stop_reg       <= 1'b1;
                     ready_reg      <= 1'b1;
                     hit_mask_reg   <= acc_next;
                     timeout_reg    <= !all_hit(acc_next);
                     shot_count_reg <= shot_count_reg + 8'd1;
                  end
               end
               ST_DONE: begin
                  if (ack) begin
                     state_reg <= ST_HOLD;
                     ready_reg <= 1'b0;
                  end
               end
               ST_HOLD: begin
                  if (tmr_hit) begin
                     if (auto_rearm) begin
                        state_reg <= ST_CLEAR;
                        clear_reg <= 1'b1;
                     end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                  ready_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign clear      = clear_reg;
   assign stop       = stop_reg;
   assign busy       = busy_reg;
   assign ready      = ready_reg;
   assign timeout    = timeout_reg;
   assign hit_mask   = hit_mask_reg;
   assign shot_count = shot_count_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed and randomized shots against a shot-level reference model that
// predicts exit cycle, hit mask, timeout and shot count from the run history.
module tb_shot_sequencer;

   localparam int WIN_W  = 16;
   localparam int HOLD_W = 12;

   logic              clk8M = 1'b0;
   logic              reset = 1'b1;
   logic              arm = 1'b0;
   logic              disarm = 1'b0;
   logic              ack = 1'b0;
   logic              auto_rearm = 1'b0;
   logic [3:0]        run = 4'h0;
   logic [WIN_W-1:0]  window_max = '0;
   logic [HOLD_W-1:0] holdoff_max = '0;
   logic              clear;
   logic              stop;
   logic              busy;
   logic              ready;
   logic              timeout;
   logic [3:0]        hit_mask;
   logic [7:0]        shot_count;
   logic [2:0]        state;

   int         errors = 0;
   int         checks = 0;
   int         exp_count = 0;
   int         total_shots = 0;
   logic [3:0] exp_mask = 4'h0;
   logic       exp_to = 1'b0;
   logic [3:0] runq[$];

   always #5 clk8M = ~clk8M;

   shot_sequencer #(
      .WIN_W  (WIN_W),
      .HOLD_W (HOLD_W)
   ) dut (
      .clk8M       (clk8M),
      .reset       (reset),
      .arm         (arm),
      .disarm      (disarm),
      .ack         (ack),
      .auto_rearm  (auto_rearm),
      .run         (run),
      .window_max  (window_max),
      .holdoff_max (holdoff_max),
      .clear       (clear),
      .stop        (stop),
      .busy        (busy),
      .ready       (ready),
      .timeout     (timeout),
      .hit_mask    (hit_mask),
      .shot_count  (shot_count),
      .state       (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk8M);
      @(negedge clk8M);
      chk("clear_stop_exclusive", 32'(clear & stop), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_clear"}, 32'(clear), 0);
      chk({tag, "_stop"}, 32'(stop), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
      chk({tag, "_hit_mask"}, 32'(hit_mask), 0);
      chk({tag, "_shot_count"}, 32'(shot_count), 0);
   endtask

   task automatic arm_seq();
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("arm_state", 32'(state), 1);
      chk("arm_clear", 32'(clear), 1);
      chk("arm_busy", 32'(busy), 1);
   endtask

   // Starts in the CLEAR cycle; runq[0] is the first non-zero run value seen
   // while armed, later entries are fed one per capture cycle.
   task automatic shot(input int wmax, input int idle);
      logic [3:0] mask;
      logic [3:0] r;
      bit         done_f;
      window_max = WIN_W'(wmax);
      run = 4'h0;
      step();
      chk("armed_state", 32'(state), 2);
      chk("armed_clear", 32'(clear), 0);
      for (int i = 0; i < idle; i++) begin
         ack = 1'($urandom);
         arm = 1'($urandom);
         step();
         ack = 1'b0;
         arm = 1'b0;
         chk("armed_wait", 32'(state), 2);
      end
      run = runq[0];
      step();
      chk("capture_entry", 32'(state), 3);
      mask = runq[0];
      done_f = 1'b0;
      for (int j = 0; j <= wmax && !done_f; j++) begin
         r = (j + 1 < runq.size()) ? runq[j + 1] : 4'h0;
         run = r;
         mask = mask | r;
         done_f = (mask == 4'hF) || (j == wmax);
         step();
         if (done_f) begin
            exp_count = (exp_count + 1) % 256;
            total_shots++;
            exp_mask = mask;
            exp_to = (mask != 4'hF);
            chk("done_state", 32'(state), 4);
            chk("done_stop", 32'(stop), 1);
            chk("done_ready", 32'(ready), 1);
            chk("done_hit_mask", 32'(hit_mask), 32'(exp_mask));
            chk("done_timeout", 32'(timeout), 32'(exp_to));
            chk("done_shot_count", 32'(shot_count), exp_count);
         end else begin
            chk("capture_state", 32'(state), 3);
            chk("capture_stop", 32'(stop), 0);
         end
      end
      run = 4'h0;
      $display("shot %0d: wmax=%0d hit_mask=%h timeout=%0d shot_count=%0d",
               total_shots, wmax, hit_mask, timeout, shot_count);
   endtask

   // From DONE: stray arm, ack, then holdoff+1 HOLD cycles with stray arms.
   task automatic ack_hold(input int h, input logic auto);
      holdoff_max = HOLD_W'(h);
      auto_rearm = auto;
      arm = 1'b1;
      step();
      arm = 1'b0;
      chk("done_arm_ignored", 32'(state), 4);
      chk("done_stop_once", 32'(stop), 0);
      chk("done_ready_held", 32'(ready), 1);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("hold_entry", 32'(state), 5);
      chk("hold_ready", 32'(ready), 0);
      chk("hold_busy", 32'(busy), 1);
      for (int i = 0; i < h; i++) begin
         arm = 1'($urandom);
         step();
         arm = 1'b0;
         chk("hold_state", 32'(state), 5);
      end
      step();
      if (auto) begin
         chk("rearm_state", 32'(state), 1);
         chk("rearm_clear", 32'(clear), 1);
      end else begin
         chk("hold_exit_state", 32'(state), 0);
         chk("hold_exit_busy", 32'(busy), 0);
      end
   endtask

   task automatic build_random(input int wmax);
      logic [3:0] miss;
      logic [3:0] v;
      runq.delete();
      miss = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      v = 4'($urandom_range(1, 15)) & ~miss;
      if (v == 4'h0) v = 4'hF & ~miss;
      runq.push_back(v);
      for (int k = 0; k <= wmax; k++) runq.push_back(4'($urandom) & ~miss);
   endtask

   initial begin
      int  wmax;
      int  h;
      logic auto;
      logic in_clear;

      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();
      chk("idle_state", 32'(state), 0);

      // Progressive hits, all four on the fourth cycle.
      arm_seq();
      runq = '{4'h1, 4'h3, 4'h7, 4'hF};
      shot(100, 2);
      chk("first_shot_count", 32'(shot_count), 1);
      chk("first_hit_mask", 32'(hit_mask), 32'hF);
      ack_hold(4, 1'b1);

      // Window expiry with only two counters firing.
      runq.delete();
      for (int k = 0; k < 12; k++) runq.push_back(4'h5);
      shot(10, 0);
      chk("expiry_timeout", 32'(timeout), 1);
      chk("expiry_hit_mask", 32'(hit_mask), 32'h5);
      ack_hold(4, 1'b0);

      // Zero-length window boundary: a single capture cycle, one-cycle hold.
      arm_seq();
      runq = '{4'h1, 4'h2};
      shot(0, 1);
      ack_hold(0, 1'b0);

      // Abort in CAPTURE together with all four run bits.
      arm_seq();
      step();
      run = 4'h1;
      step();
      chk("abort_in_capture", 32'(state), 3);
      run = 4'hF;
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      run = 4'h0;
      chk("abort_state", 32'(state), 0);
      chk("abort_stop", 32'(stop), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ready", 32'(ready), 0);
      chk("abort_count", 32'(shot_count), exp_count);
      chk("abort_hit_mask", 32'(hit_mask), 32'(exp_mask));
      chk("abort_timeout", 32'(timeout), 32'(exp_to));
      step();
      chk("abort_stop_single", 32'(stop), 0);
      $display("abort in CAPTURE: state=%0d shot_count=%0d", state, shot_count);

      // Abort from ARMED stops the counters; abort from DONE does not.
      arm_seq();
      step();
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("abort_armed_state", 32'(state), 0);
      chk("abort_armed_stop", 32'(stop), 1);
      arm_seq();
      runq = '{4'hF};
      shot(3, 0);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("abort_done_state", 32'(state), 0);
      chk("abort_done_stop", 32'(stop), 0);
      chk("abort_done_ready", 32'(ready), 0);
      chk("abort_done_hit_mask", 32'(hit_mask), 32'(exp_mask));

      // Random shots until the 8-bit counter wraps.
      in_clear = 1'b0;
      while (total_shots < 256) begin
         if (!in_clear) arm_seq();
         wmax = $urandom_range(0, 6);
         build_random(wmax);
         shot(wmax, $urandom_range(0, 3));
         h = $urandom_range(0, 3);
         auto = (total_shots < 256) ? 1'($urandom) : 1'b0;
         ack_hold(h, auto);
         in_clear = auto;
      end
      chk("wrap_count", 32'(shot_count), 0);

      // Reset while capturing: everything to zero with no stop pulse.
      arm_seq();
      runq = '{4'h2, 4'hF};
      shot(5, 0);
      ack_hold(1, 1'b0);
      arm_seq();
      step();
      run = 4'h1;
      step();
      chk("reset_pre_capture", 32'(state), 3);
      reset = 1'b1;
      run = 4'hF;
      step();
      chk_all_zero("reset_capture");
      reset = 1'b0;
      run = 4'h0;
      step();
      chk("post_reset_stop", 32'(stop), 0);
      $display("reset in CAPTURE: state=%0d stop=%0d shot_count=%0d", state, stop, shot_count);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
